// File: rtl/des_key_sched_ctrl.sv
// DES key schedule sequencer: PC-1 once, then an iterative C/D rotation walk
// that streams PC-2 subkeys K1..K16 (or K16..K1) over a valid/ready handshake.
module des_key_sched_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:64] key,
    input  logic        decrypt,
    output logic        busy,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [1:48] subkey,
    output logic [4:0]  subkey_idx,
    output logic        done
);

    // state | meaning
    // IDLE  | waiting for start; C/D/idx cleared
    // EMIT  | presenting PC-2(C||D) for round idx until 16 handshakes complete
    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [6:0] PC1_TAB [56] = '{
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
        7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
        7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
        7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
        7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
        7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
        7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
    };

    localparam logic [5:0] PC2_TAB [48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    function automatic logic [1:56] pc1(input logic [1:64] k);
        logic [1:56] r;
        r = '0;
        for (int i = 0; i < 56; i++) r[6'(i + 1)] = k[PC1_TAB[6'(i)]];
        return r;
    endfunction

    function automatic logic [1:48] pc2(input logic [1:56] cd);
        logic [1:48] r;
        r = '0;
        for (int i = 0; i < 48; i++) r[6'(i + 1)] = cd[PC2_TAB[6'(i)]];
        return r;
    endfunction

    // Rounds 1, 2, 9 and 16 shift by one; all others by two.
    function automatic logic [1:0] rot_amt(input logic [4:0] round);
        case (round)
            5'd1, 5'd2, 5'd9, 5'd16: rot_amt = 2'd1;
            default:                 rot_amt = 2'd2;
        endcase
    endfunction

    function automatic logic [1:28] rol28(input logic [1:28] x, input logic [1:0] amt);
        return (amt == 2'd1) ? {x[2:28], x[1]} : {x[3:28], x[1:2]};
    endfunction

    function automatic logic [1:28] ror28(input logic [1:28] x, input logic [1:0] amt);
        return (amt == 2'd1) ? {x[28], x[1:27]} : {x[27:28], x[1:26]};
    endfunction

    state_t      state;
    logic [1:28] c_reg;
    logic [1:28] d_reg;
    logic [4:0]  idx;
    logic [4:0]  cnt;
    logic        dir;
    logic [1:56] key_pc1;

    assign key_pc1    = pc1(key);
    assign subkey     = pc2({c_reg, d_reg});
    assign subkey_idx = idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            c_reg        <= '0;
            d_reg        <= '0;
            idx          <= '0;
            cnt          <= '0;
            dir          <= 1'b0;
            busy         <= 1'b0;
            subkey_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Decrypt starts at K16 whose cumulative shift of 28 is the identity.
                        if (decrypt) begin
                            c_reg <= key_pc1[1:28];
                            d_reg <= key_pc1[29:56];
                            idx   <= 5'd16;
                        end else begin
                            c_reg <= rol28(key_pc1[1:28], 2'd1);
                            d_reg <= rol28(key_pc1[29:56], 2'd1);
                            idx   <= 5'd1;
                        end
                        dir          <= decrypt;
                        cnt          <= '0;
                        state        <= EMIT;
                        busy         <= 1'b1;
                        subkey_valid <= 1'b1;
                    end
                end
                EMIT: begin
                    if (subkey_valid && subkey_ready) begin
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd15) begin
                            state        <= IDLE;
                            busy         <= 1'b0;
                            subkey_valid <= 1'b0;
                            done         <= 1'b1;
                            c_reg        <= '0;
                            d_reg        <= '0;
                            idx          <= '0;
                        end else if (!dir) begin
                            c_reg <= rol28(c_reg, rot_amt(idx + 5'd1));
                            d_reg <= rol28(d_reg, rot_amt(idx + 5'd1));
                            idx   <= idx + 5'd1;
                        end else begin
                            c_reg <= ror28(c_reg, rot_amt(idx));
                            d_reg <= ror28(d_reg, rot_amt(idx));
                            idx   <= idx - 5'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Bench for des_key_sched_ctrl: a cumulative-shift key schedule model checked
// against the DUT every cycle, plus directed literal and sequence checks.
module tb_des_key_sched_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] key;
    logic        decrypt;
    logic        busy;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [47:0] subkey;
    logic [4:0]  subkey_idx;
    logic        done;

    des_key_sched_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .key          (key),
        .decrypt      (decrypt),
        .busy         (busy),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .subkey       (subkey),
        .subkey_idx   (subkey_idx),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int PC1 [56] = '{
        57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
        63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2 [48] = '{
        14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
        41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int AMT [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    localparam logic [63:0] K_REF = 64'h1334_5779_9BBC_DFF1;

    // Round key r computed directly from the cumulative shift, no iteration state.
    function automatic logic [47:0] round_key(input logic [63:0] k, input int r);
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] o;
        int s;
        s = 0;
        for (int i = 1; i <= r; i++) s += AMT[i-1];
        for (int i = 0; i < 28; i++) begin
            c[27-i] = k[64-PC1[i]];
            d[27-i] = k[64-PC1[i+28]];
        end
        c = 28'((c << s) | (c >> (28 - s)));
        d = 28'((d << s) | (d >> (28 - s)));
        cd = {c, d};
        for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2[i]];
        return o;
    endfunction

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Behavioural model: which round is on offer and whether a done is due.
    logic        m_started = 1'b0;
    logic        m_active  = 1'b0;
    logic        m_done    = 1'b0;
    logic        m_dir     = 1'b0;
    int          m_pos     = 0;
    logic [47:0] m_keys [1:16];

    always @(posedge clk) begin
        m_started = 1'b1;
        if (rst) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_pos    = 0;
        end else begin
            m_done = 1'b0;
            if (m_active) begin
                if (subkey_ready) begin
                    m_pos++;
                    if (m_pos == 16) begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                    end
                end
            end else if (start) begin
                m_active = 1'b1;
                m_pos    = 0;
                m_dir    = decrypt;
                for (int r = 1; r <= 16; r++) m_keys[r] = round_key(key, r);
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            int e_idx;
            e_idx = !m_active ? 0 : (m_dir ? 16 - m_pos : m_pos + 1);
            check("valid",  64'(subkey_valid), 64'(m_active));
            check("busy",   64'(busy),         64'(m_active));
            check("done",   64'(done),         64'(m_done));
            check("idx",    64'(subkey_idx),   64'(e_idx));
            check("subkey", 64'(subkey),       m_active ? 64'(m_keys[e_idx]) : 64'd0);
        end
    end

    logic [47:0] cap_q [$];
    logic [47:0] enc_q [$];
    int          n_valid = 0;
    int          n_done  = 0;

    always @(negedge clk) begin
        if (subkey_valid && subkey_ready) cap_q.push_back(subkey);
        if (subkey_valid) n_valid++;
        if (done) n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One schedule; returns just after the negedge of the done cycle so a
    // caller may issue a back-to-back start.
    task automatic run_sched(input logic [63:0] k, input logic dec, input int ready_pct,
                             input logic noisy);
        bit got_done;
        cap_q.delete();
        n_valid = 0;
        n_done  = 0;
        got_done = 1'b0;
        key = k;
        decrypt = dec;
        start = 1'b1;
        subkey_ready = ($urandom_range(99) < ready_pct);
        tick();
        start = 1'b0;
        for (int i = 0; i < 400 && !got_done; i++) begin
            subkey_ready = ($urandom_range(99) < ready_pct);
            if (noisy) begin
                start   = ($urandom_range(2) == 0);
                decrypt = $urandom_range(1);
                key     = {$urandom, $urandom};
            end
            tick();
            start = 1'b0;
            if (done) got_done = 1'b1;
        end
        if (!got_done) check("done_timeout", 64'd0, 64'd1);
        @(negedge clk);
        #1;
    endtask

    function automatic int diff_count(input logic [47:0] a [$], input logic [47:0] b [$],
                                      input bit rev);
        int n;
        n = 0;
        if (a.size() != b.size()) return 99;
        for (int i = 0; i < a.size(); i++)
            if (a[i] !== (rev ? b[b.size()-1-i] : b[i])) n++;
        return n;
    endfunction

    initial begin
        rst = 1'b1;
        start = 1'b0;
        key = '0;
        decrypt = 1'b0;
        subkey_ready = 1'b0;
        repeat (3) tick();
        check("rst_valid",  64'(subkey_valid), 64'd0);
        check("rst_busy",   64'(busy),         64'd0);
        check("rst_idx",    64'(subkey_idx),   64'd0);
        check("rst_subkey", 64'(subkey),       64'd0);

        check("model_k1",  64'(round_key(K_REF, 1)),  64'h1B02EFFC7072);
        check("model_k2",  64'(round_key(K_REF, 2)),  64'h79AED9DBC9E5);
        check("model_k16", 64'(round_key(K_REF, 16)), 64'hCB3D8B0E17F5);
        rst = 1'b0;
        tick();

        run_sched(K_REF, 1'b0, 100, 1'b0);
        check("enc_first", 64'(cap_q.size() > 0 ? cap_q[0] : 48'd0), 64'h1B02EFFC7072);
        check("enc_second", 64'(cap_q.size() > 1 ? cap_q[1] : 48'd0), 64'h79AED9DBC9E5);
        check("enc_last", 64'(cap_q.size() == 16 ? cap_q[15] : 48'd0), 64'hCB3D8B0E17F5);
        check("enc_valid_cycles", 64'(n_valid), 64'd16);
        check("enc_done_pulses", 64'(n_done), 64'd1);
        enc_q = cap_q;
        tick();

        run_sched(K_REF, 1'b1, 100, 1'b0);
        check("dec_first", 64'(cap_q.size() > 0 ? cap_q[0] : 48'd0), 64'hCB3D8B0E17F5);
        check("dec_last", 64'(cap_q.size() == 16 ? cap_q[15] : 48'd0), 64'h1B02EFFC7072);
        check("dec_reversed", 64'(diff_count(cap_q, enc_q, 1'b1)), 64'd0);
        check("dec_done_pulses", 64'(n_done), 64'd1);
        tick();

        run_sched(K_REF, 1'b0, 40, 1'b0);
        check("bp_sequence", 64'(diff_count(cap_q, enc_q, 1'b0)), 64'd0);
        check("bp_done_pulses", 64'(n_done), 64'd1);
        tick();

        run_sched(K_REF, 1'b0, 40, 1'b1);
        check("noisy_sequence", 64'(diff_count(cap_q, enc_q, 1'b0)), 64'd0);
        check("noisy_done_pulses", 64'(n_done), 64'd1);
        tick();

        // Abort on the edge that would be the 7th handshake.
        key = K_REF;
        decrypt = 1'b0;
        start = 1'b1;
        subkey_ready = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        n_done = 0;
        rst = 1'b1;
        tick();
        check("abort_valid",  64'(subkey_valid), 64'd0);
        check("abort_idx",    64'(subkey_idx),   64'd0);
        check("abort_subkey", 64'(subkey),       64'd0);
        rst = 1'b0;
        repeat (3) tick();
        check("abort_no_done", 64'(n_done), 64'd0);
        run_sched(K_REF, 1'b0, 100, 1'b0);
        check("restart_k1", 64'(cap_q.size() > 0 ? cap_q[0] : 48'd0), 64'h1B02EFFC7072);
        check("restart_count", 64'(cap_q.size()), 64'd16);

        // Back-to-back: the next start lands in the done cycle.
        begin
            logic [63:0] k2;
            k2 = {$urandom, $urandom};
            run_sched(k2, 1'b0, 70, 1'b0);
            check("b2b_k1", 64'(cap_q.size() > 0 ? cap_q[0] : 48'd0), 64'(round_key(k2, 1)));
            check("b2b_count", 64'(cap_q.size()), 64'd16);
            check("b2b_done_pulses", 64'(n_done), 64'd1);
        end
        tick();

        for (int i = 0; i < 800; i++) begin
            subkey_ready = ($urandom_range(99) < 40);
            start        = ($urandom_range(3) == 0);
            decrypt      = $urandom_range(1);
            key          = {$urandom, $urandom};
            tick();
        end
        start = 1'b0;
        subkey_ready = 1'b1;
        repeat (20) tick();
        check("final_idle", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
